// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file access controller: default
// geometry, the controller state encoding and the hardwired-zero address.
package regfile_ctrl_pkg;

    // Default register-file geometry (32 x 32-bit, 5-bit addresses).
    localparam int XLEN_DEF  = 32;
    localparam int AW_DEF    = 5;
    localparam int NREGS_DEF = 32;

    // Architectural zero register; writes to it never reach the array.
    localparam int X0_ADDR = 0;

    // Controller states.
    //   CLEAR  : zero-fill x1..x(NREGS-1) after reset
    //   IDLE   : core owns the register file
    //   DRAIN  : core stalled, last core writeback still allowed through
    //   ACCESS : debug requester owns the write port and read port 2
    //   ACK    : completion pulse to the debug requester
    typedef enum logic [2:0] {
        CLEAR  = 3'd0,
        IDLE   = 3'd1,
        DRAIN  = 3'd2,
        ACCESS = 3'd3,
        ACK    = 3'd4
    } state_t;

endpackage

// File: rtl/regfile_ctrl.sv
// Register-file access controller. Sits between the core pipeline / debug
// module and the regfile instance: clears x1..x(NREGS-1) after reset, passes
// core traffic through in IDLE, and hands the write port and read port 2 to
// the debug requester once the core has been stalled and drained.
import regfile_ctrl_pkg::*;

module regfile_ctrl #(
    parameter int XLEN  = XLEN_DEF,
    parameter int AW    = AW_DEF,
    parameter int NREGS = NREGS_DEF
) (
    input  logic            clk,
    input  logic            reset,

    input  logic [AW-1:0]   core_ra1,
    input  logic [AW-1:0]   core_ra2,
    output logic [XLEN-1:0] core_r1,
    output logic [XLEN-1:0] core_r2,
    input  logic            core_we,
    input  logic [AW-1:0]   core_wa,
    input  logic [XLEN-1:0] core_wd,
    output logic            core_stall,
    output logic            init_done,

    input  logic            dbg_req,
    input  logic            dbg_we,
    input  logic [AW-1:0]   dbg_addr,
    input  logic [XLEN-1:0] dbg_wdata,
    output logic            dbg_ack,
    output logic [XLEN-1:0] dbg_rdata,

    output logic [AW-1:0]   rf_ra1,
    output logic [AW-1:0]   rf_ra2,
    input  logic [XLEN-1:0] rf_r1,
    input  logic [XLEN-1:0] rf_r2,
    output logic            rf_we,
    output logic [AW-1:0]   rf_wa,
    output logic [XLEN-1:0] rf_wd
);

    state_t          r_state;
    state_t          w_next_state;
    logic [AW-1:0]   r_clr_cnt;
    logic            r_init_done;
    logic [XLEN-1:0] r_dbg_rdata;

    logic            w_clr_last;
    logic            w_we_req;
    logic [AW-1:0]   w_wa;
    logic [XLEN-1:0] w_wd;
    logic [AW-1:0]   w_ra2;
    logic            w_dbg_is_x0;

    assign w_clr_last  = (r_clr_cnt == AW'(NREGS - 1));
    assign w_dbg_is_x0 = (dbg_addr == AW'(X0_ADDR));

    // State register; reset always restarts the clear sequence and drops
    // any debug transaction in flight without acknowledging it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: clear once, then serve debug requests from IDLE
    // through a fixed DRAIN -> ACCESS -> ACK sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            CLEAR:   if (w_clr_last) w_next_state = IDLE;
            IDLE:    if (dbg_req)    w_next_state = DRAIN;
            DRAIN:   w_next_state = ACCESS;
            ACCESS:  w_next_state = ACK;
            ACK:     w_next_state = IDLE;
            default: w_next_state = CLEAR;
        endcase
    end

    // Clear address counter; x0 is hardwired so the sweep starts at x1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clr_cnt <= AW'(1);
        end else if (r_state == CLEAR) begin
            r_clr_cnt <= r_clr_cnt + AW'(1);
        end
    end

    // Sticky completion flag, set on the cycle the last register is written.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_init_done <= 1'b0;
        end else if ((r_state == CLEAR) && w_clr_last) begin
            r_init_done <= 1'b1;
        end
    end

    // Debug read capture: port 2 shows the pre-write value during ACCESS,
    // and x0 is forced to read as zero whatever the array holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dbg_rdata <= '0;
        end else if (r_state == ACCESS) begin
            r_dbg_rdata <= w_dbg_is_x0 ? '0 : rf_r2;
        end
    end

    // Write-port and read-port-2 ownership per state; the core keeps its
    // writeback through DRAIN so an in-flight result is not lost.
    always_comb begin
        w_ra2    = core_ra2;
        w_we_req = 1'b0;
        w_wa     = core_wa;
        w_wd     = core_wd;
        case (r_state)
            CLEAR: begin
                w_we_req = 1'b1;
                w_wa     = r_clr_cnt;
                w_wd     = '0;
            end
            IDLE, DRAIN: begin
                w_we_req = core_we;
            end
            ACCESS: begin
                w_ra2    = dbg_addr;
                w_we_req = dbg_we;
                w_wa     = dbg_addr;
                w_wd     = dbg_wdata;
            end
            default: begin
                w_we_req = 1'b0;
            end
        endcase
    end

    // Writes are suppressed while reset is held and whenever they target x0.
    assign rf_we  = w_we_req & ~reset & (w_wa != AW'(X0_ADDR));
    assign rf_wa  = w_wa;
    assign rf_wd  = w_wd;
    assign rf_ra1 = core_ra1;
    assign rf_ra2 = w_ra2;

    assign core_r1 = rf_r1;
    assign core_r2 = rf_r2;

    // Status outputs read as their reset values for as long as reset is high.
    assign core_stall = reset | (r_state != IDLE);
    assign init_done  = r_init_done & ~reset;
    assign dbg_ack    = ~reset & (r_state == ACK);
    assign dbg_rdata  = reset ? '0 : r_dbg_rdata;

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl with a behavioural register array
// attached and a register-content model kept at transaction level.
module tb_regfile_ctrl;

    localparam int XLEN  = 32;
    localparam int AW    = 5;
    localparam int NREGS = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [AW-1:0]   core_ra1 = '0;
    logic [AW-1:0]   core_ra2 = '0;
    logic [XLEN-1:0] core_r1;
    logic [XLEN-1:0] core_r2;
    logic            core_we = 1'b0;
    logic [AW-1:0]   core_wa = '0;
    logic [XLEN-1:0] core_wd = '0;
    logic            core_stall;
    logic            init_done;
    logic            dbg_req = 1'b0;
    logic            dbg_we = 1'b0;
    logic [AW-1:0]   dbg_addr = '0;
    logic [XLEN-1:0] dbg_wdata = '0;
    logic            dbg_ack;
    logic [XLEN-1:0] dbg_rdata;
    logic [AW-1:0]   rf_ra1;
    logic [AW-1:0]   rf_ra2;
    logic [XLEN-1:0] rf_r1;
    logic [XLEN-1:0] rf_r2;
    logic            rf_we;
    logic [AW-1:0]   rf_wa;
    logic [XLEN-1:0] rf_wd;

    regfile_ctrl #(.XLEN(XLEN), .AW(AW), .NREGS(NREGS)) dut (
        .clk(clk), .reset(reset),
        .core_ra1(core_ra1), .core_ra2(core_ra2),
        .core_r1(core_r1), .core_r2(core_r2),
        .core_we(core_we), .core_wa(core_wa), .core_wd(core_wd),
        .core_stall(core_stall), .init_done(init_done),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_r1(rf_r1), .rf_r2(rf_r2),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    // Behavioural register file: combinational reads, synchronous write.
    logic [XLEN-1:0] rfMem [0:NREGS-1];
    assign rf_r1 = rfMem[rf_ra1];
    assign rf_r2 = rfMem[rf_ra2];
    always @(posedge clk) begin
        if (rf_we) rfMem[rf_wa] <= rf_wd;
    end

    // Expected architectural contents of every register.
    logic [XLEN-1:0] expRegs [0:NREGS-1];

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic            we;
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] wdata;
        logic            drainWe;
        logic [AW-1:0]   drainWa;
        logic [XLEN-1:0] drainWd;
        logic [XLEN-1:0] expRdata;
    } dbgVec_t;

    dbgVec_t vecs [9];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of one debug transaction: the drain-cycle core write lands
    // first, the read returns the pre-write value, x0 is never written.
    function automatic logic [XLEN-1:0] modelDbg(input logic we, input logic [AW-1:0] addr,
                                                 input logic [XLEN-1:0] wdata,
                                                 input logic drainWe, input logic [AW-1:0] drainWa,
                                                 input logic [XLEN-1:0] drainWd);
        logic [XLEN-1:0] rd;
        if (drainWe && drainWa != 0) expRegs[drainWa] = drainWd;
        rd = (addr == 0) ? '0 : expRegs[addr];
        if (we && addr != 0) expRegs[addr] = wdata;
        return rd;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < NREGS; i++) expRegs[i] = '0;
    endtask

    // Reset checks, then the 31-cycle clear sweep and init_done rise.
    task automatic clearSequence();
        core_we = 1'b1; core_wa = 5'd3; core_wd = 32'hFFFF_FFFF;
        tick();
        checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
        checkOutput("reset_flags", 32'({init_done, core_stall, dbg_ack}), 32'b010);
        checkOutput("reset_dbg_rdata", dbg_rdata, 32'd0);
        reset = 1'b0;
        #1;
        for (int cyc = 1; cyc <= 31; cyc++) begin
            checkOutput($sformatf("clear_we_c%0d", cyc), 32'(rf_we), 32'd1);
            checkOutput($sformatf("clear_wa_c%0d", cyc), 32'(rf_wa), 32'(cyc));
            checkOutput($sformatf("clear_wd_c%0d", cyc), rf_wd, 32'd0);
            checkOutput($sformatf("clear_flags_c%0d", cyc),
                        32'({init_done, core_stall, dbg_ack}), 32'b010);
            tick();
        end
        core_we = 1'b0;
        #1;
        checkOutput("clear_done_flags", 32'({init_done, core_stall, dbg_ack}), 32'b100);
        modelClear();
    endtask

    task automatic readbackAll(input string tag);
        for (int i = 0; i < NREGS; i++) begin
            core_ra1 = AW'(i);
            core_ra2 = AW'(NREGS - 1 - i);
            #1;
            checkOutput($sformatf("%s_r1_x%0d", tag, i), core_r1, expRegs[i]);
            checkOutput($sformatf("%s_r2_x%0d", tag, NREGS - 1 - i), core_r2, expRegs[NREGS - 1 - i]);
        end
    endtask

    task automatic coreWrite(input logic [AW-1:0] addr, input logic [XLEN-1:0] data);
        core_we = 1'b1; core_wa = addr; core_wd = data;
        checkOutput("core_wr_stall", 32'(core_stall), 32'd0);
        tick();
        core_we = 1'b0;
        if (addr != 0) expRegs[addr] = data;
        core_ra1 = addr;
        #1;
        checkOutput($sformatf("core_wr_x%0d", addr), core_r1, expRegs[addr]);
        checkOutput("core_wr_stall_after", 32'(core_stall), 32'd0);
    endtask

    // One debug transaction from IDLE with a core write offered in DRAIN
    // and a bogus core write offered in ACCESS (which must be ignored).
    task automatic applyStimulus(input string tag, input logic we, input logic [AW-1:0] addr,
                                 input logic [XLEN-1:0] wdata, input logic drainWe,
                                 input logic [AW-1:0] drainWa, input logic [XLEN-1:0] drainWd,
                                 input logic [XLEN-1:0] expRdata);
        int latency;
        int stallCycles;
        logic gotAck;
        checkOutput({tag, "_idle_stall"}, 32'(core_stall), 32'd0);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        core_we = 1'b0;
        latency = 0; stallCycles = 0; gotAck = 1'b0;
        while (!gotAck && latency < 10) begin
            tick();
            latency++;
            if (core_stall) stallCycles++;
            if (dbg_ack) gotAck = 1'b1;
            if (latency == 1) begin
                core_we = drainWe; core_wa = drainWa; core_wd = drainWd;
            end else if (latency == 2) begin
                core_we = 1'b1; core_wa = ~addr; core_wd = 32'hBAD0_0000 | 32'(addr);
            end else begin
                core_we = 1'b0;
            end
        end
        checkOutput({tag, "_latency"}, 32'(latency), 32'd3);
        checkOutput({tag, "_stall_cycles"}, 32'(stallCycles), 32'd3);
        checkOutput({tag, "_rdata"}, dbg_rdata, expRdata);
        dbg_req = 1'b0; core_we = 1'b0;
        tick();
        checkOutput({tag, "_after_ack"}, 32'({dbg_ack, core_stall}), 32'b00);
        checkOutput({tag, "_rdata_held"}, dbg_rdata, expRdata);
    endtask

    initial begin
        logic [XLEN-1:0] exp;
        int cyc;
        int earlyAck;

        for (int i = 0; i < NREGS; i++) rfMem[i] = (i == 0) ? '0 : $urandom;
        for (int i = 0; i < NREGS; i++) expRegs[i] = rfMem[i];

        vecs[0] = '{1'b1, 5'd7,  32'hDEAD_BEEF, 1'b1, 5'd3, 32'h0000_0011, 32'h0000_0000};
        vecs[1] = '{1'b0, 5'd7,  32'h0000_0000, 1'b0, 5'd0, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 5'd3,  32'h0000_0000, 1'b0, 5'd0, 32'h0000_0000, 32'h0000_0011};
        vecs[3] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0000_0000, 32'h0000_0000};
        vecs[4] = '{1'b0, 5'd0,  32'h0000_0000, 1'b0, 5'd0, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{1'b0, 5'd9,  32'h0000_0000, 1'b1, 5'd9, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        vecs[6] = '{1'b1, 5'd31, 32'h0000_0001, 1'b1, 5'd0, 32'h0000_0077, 32'h0000_0000};
        vecs[7] = '{1'b0, 5'd31, 32'h0000_0000, 1'b0, 5'd0, 32'h0000_0000, 32'h0000_0001};
        vecs[8] = '{1'b0, 5'd5,  32'h0000_0000, 1'b0, 5'd0, 32'h0000_0000, 32'h1234_5678};

        tick();
        clearSequence();
        readbackAll("post_clear");

        coreWrite(5'd5, 32'h1234_5678);

        for (int v = 0; v < 9; v++) begin
            exp = modelDbg(vecs[v].we, vecs[v].addr, vecs[v].wdata,
                           vecs[v].drainWe, vecs[v].drainWa, vecs[v].drainWd);
            applyStimulus($sformatf("vec%0d", v), vecs[v].we, vecs[v].addr, vecs[v].wdata,
                          vecs[v].drainWe, vecs[v].drainWa, vecs[v].drainWd, vecs[v].expRdata);
            checkOutput($sformatf("vec%0d_model", v), dbg_rdata, exp);
        end
        readbackAll("post_table");

        for (int n = 0; n < 40; n++) begin
            logic            rWe, rDWe;
            logic [AW-1:0]   rAddr, rDWa;
            logic [XLEN-1:0] rData, rDWd;
            rWe   = 1'($urandom_range(0, 1));
            rDWe  = 1'($urandom_range(0, 1));
            rAddr = AW'($urandom_range(0, NREGS - 1));
            rDWa  = AW'($urandom_range(0, NREGS - 1));
            rData = $urandom;
            rDWd  = $urandom;
            if ($urandom_range(0, 2) == 0) begin
                coreWrite(rAddr, rData);
            end else begin
                exp = modelDbg(rWe, rAddr, rData, rDWe, rDWa, rDWd);
                applyStimulus($sformatf("rnd%0d", n), rWe, rAddr, rData, rDWe, rDWa, rDWd, exp);
            end
        end
        readbackAll("post_random");

        // Debug request raised while clearing waits for the first IDLE cycle.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5; dbg_wdata = '0;
        #1;
        cyc = 1; earlyAck = 0;
        while (!dbg_ack && cyc < 60) begin
            tick();
            cyc++;
            if (dbg_ack && !init_done) earlyAck++;
        end
        modelClear();
        checkOutput("clr_req_early_ack", 32'(earlyAck), 32'd0);
        checkOutput("clr_req_ack_cycle", 32'(cyc), 32'd35);
        checkOutput("clr_req_rdata", dbg_rdata, 32'd0);
        dbg_req = 1'b0;
        tick();

        // Reset landing in ACCESS aborts the transaction and re-clears.
        coreWrite(5'd12, 32'h0000_0055);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'hCAFE_F00D;
        tick();
        tick();
        checkOutput("abort_in_access_stall", 32'({core_stall, dbg_ack}), 32'b10);
        reset = 1'b1;
        #1;
        checkOutput("abort_rf_we", 32'(rf_we), 32'd0);
        tick();
        checkOutput("abort_no_ack", 32'(dbg_ack), 32'd0);
        dbg_req = 1'b0;
        clearSequence();
        readbackAll("post_abort");

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
